// File: rtl/derivador_pd_pkg.sv
// Shared fixed-point definitions for the servomotor controller gain blocks:
// Q-format sizes, derivative gain, saturation helpers and FSM encoding.
package derivador_pd_pkg;

   localparam int MAGNITUD = 17;
   localparam int DECIMAL  = 0;
   localparam int N        = MAGNITUD + DECIMAL + 1;
   localparam int KD       = 3;

   // State encoding of the priming/run machine
   localparam logic PRIMING = 1'b0;
   localparam logic RUN     = 1'b1;

   // Largest representable value of an n-bit signed word
   function automatic longint sat_max(input int n);
      return (longint'(1) <<< (n - 1)) - longint'(1);
   endfunction

   // Smallest representable value of an n-bit signed word
   function automatic longint sat_min(input int n);
      return -(longint'(1) <<< (n - 1));
   endfunction

   localparam logic signed [2*N-1:0] SAT_MAX = (2*N)'(sat_max(N));
   localparam logic signed [2*N-1:0] SAT_MIN = (2*N)'(sat_min(N));

   // Clamp a sign-extended wide value (up to 2N bits) into an N-bit word
   function automatic logic signed [N-1:0] saturate(input logic signed [2*N-1:0] x);
      logic signed [N-1:0] r;
      if (x > SAT_MAX) begin
         r = SAT_MAX[N-1:0];
      end else if (x < SAT_MIN) begin
         r = SAT_MIN[N-1:0];
      end else begin
         r = x[N-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/derivador_pd_if.sv
// Sample/result bundle between the controller and the derivative block.
interface derivador_pd_if
   import derivador_pd_pkg::*;
#(
   parameter int W = N
);
   logic                enable;
   logic                clear;
   logic signed [W-1:0] error;
   logic signed [W-1:0] derivador;
   logic                valid;

   modport master (
      output enable,
      output clear,
      output error,
      input  derivador,
      input  valid
   );

   modport slave (
      input  enable,
      input  clear,
      input  error,
      output derivador,
      output valid
   );
endinterface

// File: rtl/derivador_pd_mult_sat.sv
// Combinational signed Q-format multiply: full-width product, arithmetic
// right shift by the fractional bits (floor), then clamp to W bits.
module mult_sat #(
   parameter int W    = 18,
   parameter int FRAC = 0
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] y
);

   localparam logic signed [2*W-1:0] MAX_W = {{(W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W-1:0] MIN_W = {{(W+1){1'b1}}, {(W-1){1'b0}}};

   logic signed [2*W-1:0] a_w;
   logic signed [2*W-1:0] b_w;
   logic signed [2*W-1:0] prod_s;
   logic signed [2*W-1:0] shr_s;

   // Widen, multiply, rescale and clamp
   always_comb begin
      a_w    = (2*W)'(a);
      b_w    = (2*W)'(b);
      prod_s = a_w * b_w;
      shr_s  = prod_s >>> FRAC;
      if (shr_s > MAX_W) begin
         y = MAX_W[W-1:0];
      end else if (shr_s < MIN_W) begin
         y = MIN_W[W-1:0];
      end else begin
         y = shr_s[W-1:0];
      end
   end

endmodule

// File: rtl/derivador_pd.sv
// Derivative term KD*(e[n]-e[n-1]) of the I_PD controller. Three register
// stages: capture, saturated difference, saturated gain product.
module derivador_pd
   import derivador_pd_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   derivador_pd_if.slave bus
);

   localparam logic signed [N-1:0] KD_Q = N'(KD * (2 ** DECIMAL));

   logic                state_q, state_d;
   logic                prim_s;

   logic signed [N-1:0] prev_q, prev_d;
   logic signed [N-1:0] s1_err_q, s1_err_d;
   logic signed [N-1:0] s1_prev_q, s1_prev_d;
   logic                s1_vld_q, s1_vld_d;
   logic signed [N:0]   diff_w_s;
   logic signed [N-1:0] s2_diff_q, s2_diff_d;
   logic                s2_vld_q, s2_vld_d;
   logic signed [N-1:0] prod_s;
   logic signed [N-1:0] der_q, der_d;
   logic                vld_q, vld_d;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= PRIMING;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: clear re-primes, the first accepted sample starts RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         PRIMING: begin
            if (bus.clear) begin
               state_d = PRIMING;
            end else if (bus.enable) begin
               state_d = RUN;
            end else begin
               state_d = PRIMING;
            end
         end
         RUN: begin
            if (bus.clear) begin
               state_d = PRIMING;
            end else begin
               state_d = RUN;
            end
         end
         default: state_d = PRIMING;
      endcase
   end

   // FSM output: in PRIMING the sample is differenced against itself
   always_comb begin
      prim_s = 1'b0;
      case (state_q)
         PRIMING: prim_s = 1'b1;
         RUN:     prim_s = 1'b0;
         default: prim_s = 1'b1;
      endcase
   end

   // Stage 1: capture the sample and the previous sample, update history
   always_comb begin
      prev_d    = prev_q;
      s1_err_d  = s1_err_q;
      s1_prev_d = s1_prev_q;
      s1_vld_d  = 1'b0;
      if (bus.clear) begin
         prev_d    = '0;
         s1_err_d  = '0;
         s1_prev_d = '0;
      end else if (bus.enable) begin
         prev_d    = bus.error;
         s1_err_d  = bus.error;
         s1_prev_d = prim_s ? bus.error : prev_q;
         s1_vld_d  = 1'b1;
      end else begin
         s1_vld_d  = 1'b0;
      end
   end

   // Stage 2: one-bit-wider difference, clamped back to N bits
   always_comb begin
      diff_w_s  = (N+1)'(s1_err_q) - (N+1)'(s1_prev_q);
      s2_diff_d = s2_diff_q;
      s2_vld_d  = 1'b0;
      if (bus.clear) begin
         s2_diff_d = '0;
      end else if (s1_vld_q) begin
         s2_diff_d = saturate((2*N)'(diff_w_s));
         s2_vld_d  = 1'b1;
      end else begin
         s2_vld_d  = 1'b0;
      end
   end

   mult_sat #(
      .W    (N),
      .FRAC (DECIMAL)
   ) u_mult_sat (
      .a (s2_diff_q),
      .b (KD_Q),
      .y (prod_s)
   );

   // Stage 3: register the gain product; hold it between samples
   always_comb begin
      der_d = der_q;
      vld_d = 1'b0;
      if (bus.clear) begin
         der_d = '0;
      end else if (s2_vld_q) begin
         der_d = prod_s;
         vld_d = 1'b1;
      end else begin
         vld_d = 1'b0;
      end
   end

   // Pipeline and history registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_q    <= '0;
         s1_err_q  <= '0;
         s1_prev_q <= '0;
         s1_vld_q  <= 1'b0;
         s2_diff_q <= '0;
         s2_vld_q  <= 1'b0;
         der_q     <= '0;
         vld_q     <= 1'b0;
      end else begin
         prev_q    <= prev_d;
         s1_err_q  <= s1_err_d;
         s1_prev_q <= s1_prev_d;
         s1_vld_q  <= s1_vld_d;
         s2_diff_q <= s2_diff_d;
         s2_vld_q  <= s2_vld_d;
         der_q     <= der_d;
         vld_q     <= vld_d;
      end
   end

   assign bus.derivador = der_q;
   assign bus.valid     = vld_q;

endmodule

// File: tb/tb_derivador_pd.sv
// Scoreboard bench for derivador_pd: directed scenarios plus random traffic,
// expectations from an integer model of KD*(e[n]-e[n-1]) with clamping.
module tb_derivador_pd;
   import derivador_pd_pkg::*;

   typedef struct {
      longint val;
      int     cyc;
   } exp_t;

   logic clk;
   logic reset;
   int   cyc;
   int   total;
   int   bad;

   exp_t   sb[$];
   longint hold_ref;
   longint prev_m;
   bit     have_prev;

   derivador_pd_if bus ();

   derivador_pd dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic longint clamp(input longint v);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (N - 1)) - 1;
      lo = -(longint'(1) <<< (N - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Offer one sample for one cycle and record what it should produce
   task automatic send(input longint e);
      exp_t x;
      longint d;
      bus.enable = 1'b1;
      bus.clear  = 1'b0;
      bus.error  = N'(e);
      if (!have_prev) begin
         x.val = 0;
      end else begin
         d     = clamp(e - prev_m);
         x.val = clamp((d * longint'(KD * (2 ** DECIMAL))) >>> DECIMAL);
      end
      prev_m    = e;
      have_prev = 1'b1;
      x.cyc     = cyc;
      sb.push_back(x);
      @(posedge clk) #1;
      bus.enable = 1'b0;
   endtask

   task automatic idle(input int n);
      bus.enable = 1'b0;
      repeat (n) @(posedge clk) #1;
   endtask

   // Synchronous flush with a competing sample that must be discarded
   task automatic do_clear();
      bus.clear  = 1'b1;
      bus.enable = 1'b1;
      bus.error  = N'(777);
      @(posedge clk) #1;
      bus.clear  = 1'b0;
      bus.enable = 1'b0;
      sb.delete();
      hold_ref  = 0;
      have_prev = 1'b0;
      total++;
      if (bus.derivador !== '0 || bus.valid !== 1'b0) begin
         bad++;
         $display("FAIL clear_zero: derivador=%0d valid=%0b want 0/0", bus.derivador, bus.valid);
      end
   endtask

   // Monitor: pop and compare on every valid pulse, check hold otherwise
   always @(negedge clk) begin
      exp_t x;
      if (reset === 1'b1 && bus.valid === 1'b1) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL spurious_valid: derivador=%0d want no pulse", bus.derivador);
         end else begin
            x = sb.pop_front();
            if (longint'(bus.derivador) != x.val) begin
               bad++;
               $display("FAIL value: derivador=%0d want %0d", bus.derivador, x.val);
            end
            total++;
            if (cyc - x.cyc != 3) begin
               bad++;
               $display("FAIL latency: got %0d edges want 3", cyc - x.cyc);
            end
            hold_ref = x.val;
         end
      end else begin
         total++;
         if (bus.valid !== 1'b0 || longint'(bus.derivador) != hold_ref) begin
            bad++;
            $display("FAIL hold: derivador=%0d valid=%0b want %0d/0", bus.derivador, bus.valid, hold_ref);
         end
      end
   end

   initial begin
      longint v;
      int     r;
      total      = 0;
      bad        = 0;
      cyc        = 0;
      hold_ref   = 0;
      prev_m     = 0;
      have_prev  = 1'b0;
      reset      = 1'b0;
      bus.enable = 1'b0;
      bus.clear  = 1'b0;
      bus.error  = '0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (bus.derivador !== '0 || bus.valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: derivador=%0d valid=%0b want 0/0", bus.derivador, bus.valid);
      end
      reset = 1'b1;
      idle(2);

      // priming then a step of 50
      send(100);
      idle(4);
      send(150);
      idle(4);

      // ramp with continuous enable
      do_clear();
      send(0); send(10); send(20); send(30);
      idle(4);

      // saturation in both directions
      send(-131072); send(131071);
      idle(4);
      send(131071); send(-131072);
      idle(4);

      // gaps: history and output held across idle cycles
      send(40); idle(5); send(20); idle(5);

      // clear with two samples in flight, then re-prime
      send(1000); send(-3000);
      do_clear();
      idle(3);
      send(500); idle(4);
      send(-700); idle(4);

      // async reset mid-pipeline, off the clock edge
      send(1234); send(-4321);
      #2;
      reset = 1'b0;
      sb.delete();
      hold_ref  = 0;
      have_prev = 1'b0;
      #1;
      total++;
      if (bus.derivador !== '0 || bus.valid !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: derivador=%0d valid=%0b want 0/0", bus.derivador, bus.valid);
      end
      @(posedge clk) #3;
      reset = 1'b1;
      @(posedge clk) #1;
      send(900); idle(4);
      send(880); idle(4);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            do_clear();
         end else if (r < 14) begin
            if ($urandom_range(0, 3) == 0) begin
               v = longint'($urandom_range(0, 262143)) - 131072;
            end else begin
               v = longint'($urandom_range(0, 2000)) - 1000;
            end
            send(v);
         end else begin
            idle(1);
         end
      end

      // drain with a bounded wait
      for (int k = 0; k < 10 && sb.size() != 0; k++) begin
         @(posedge clk) #1;
      end
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d results outstanding want 0", sb.size());
      end
      idle(2);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/derivador_pd.md
Name: derivador_pd

Overview:
- Discrete-time derivative term of the servomotor I_PD controller; the differentiating counterpart of the integrator.
- On each sample strobe it computes KD*(e[n] - e[n-1]) in signed fixed point, with saturation.
- Three-stage pipeline. Produces a valid-qualified output that the controller summing stage combines with the proportional and integral terms.

Parameters:
- Magnitud, 17, integer magnitude bits of the fixed-point word.
- Decimal, 0, fractional bits of the fixed-point word.
- N, Magnitud+Decimal+1, total signed word width (sign + magnitude + fraction).
- KD, 3 (integer, i.e. 3<<Decimal in fixed point), signed N-bit derivative gain in the same Q format.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  sample strobe; error is captured when high.
- clear  input  1  synchronous flush of history and pipeline; returns to PRIMING.
- error  input  N  signed error sample e[n].
- derivador  output  N  signed KD*(e[n]-e[n-1]), saturated.
- valid  output  1  one-cycle pulse per completed sample; derivador is held between pulses.

Behaviour:
- Reset (reset=0, async): all pipeline registers, the previous-sample register, derivador and valid are cleared to 0. The state machine goes to PRIMING.
- State machine, two states:
  - PRIMING: first sample after reset or clear. The differencing stage treats e[n-1] := e[n], so the difference is 0. On enable, go to RUN.
  - RUN: normal differencing. Leaves RUN only on reset or clear.
- Stage 1 (enable=1 at cycle t):
  - error is registered into s1_err and s1_vld is set.
  - prev is updated to error on the same edge. Old prev is held in s1_prev (in PRIMING, s1_prev := error).
- Stage 2 (t+1): diff = s1_err - s1_prev is computed at N+1 bits, saturated to [-2^(N-1), 2^(N-1)-1] and registered.
- Stage 3 (t+2): prod = KD * diff is computed at 2N bits and arithmetic-shifted right by Decimal (truncation toward -inf). It is saturated to N bits and registered into derivador with valid=1.
- Timing and throughput:
  - Latency is 3 clk edges from the enable edge to the valid edge.
  - Throughput is one sample per cycle; enable may be held high continuously.
- enable=0: no capture, prev is held, no new valid. In-flight stages still drain.
- valid is high exactly one cycle per sample. derivador holds its last value otherwise.
- clear=1 (sync, has priority over enable in the same cycle):
  - Zeroes all pipeline registers, prev, derivador and valid. The sample offered that cycle is discarded.
  - State goes to PRIMING.
  - In-flight samples are dropped (no valid emitted for them).
- Reset mid-operation behaves the same as clear, but asynchronously.
- Saturation is applied at both the difference and the product stage. No wrap-around is ever observable on derivador.

Decomposition:
- Shared package holds the fixed-point helpers:
  - SAT_MAX/SAT_MIN constant functions of N.
  - A saturate(N+k → N) function.
  - State encoding localparams PRIMING=1'b0, RUN=1'b1.
- Sub-module: mult_sat, a parameterised signed multiply with Q-format shift and saturation. It is combinational and reused by the other controller gain blocks.
- Pipeline registers stay inline.

Test Plan:
- Reset release, enable pulse with error=100 → 3 edges later valid=1, derivador=0 (priming). Then enable with error=150 → derivador=150 (3*50).
- Continuous enable with ramp error=0,10,20,30 (N=18, KD=3) → valid every cycle after 3-cycle latency, outputs 0,30,30,30.
- Positive saturation: error=-131072 then 131071 → diff saturates to 131071, derivador=131071. Reverse order → derivador=-131072.
- Gaps: enable pulses separated by 5 idle cycles, errors 40 then 20 → derivador=-60. prev is held across idle cycles and derivador is held between valid pulses.
- clear asserted while two samples are in flight → no valid for them, outputs 0. Next sample (error=500) → derivador=0 (priming).
- Async reset asserted mid-pipeline, not aligned to clk → derivador=0 and valid=0 immediately. After release, first sample → 0 (priming).
